// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/Adder1bit.sv
// 1-bit full adder cell used as the serial datapath element.
module Adder1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through a single
// full adder cell with a registered carry, one bit per clock.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int                CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             c_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;

  Adder1bit u_fa (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (c_q),
    .S   (fa_s),
    .Cout(fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign s_next   = {fa_s, s_sh[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: IDLE -> ADD on accept, ADD -> HOLD after the last bit, HOLD -> IDLE on output accept.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (In_valid)  next_state = ST_ADD;
      ST_ADD:  if (last_bit)  next_state = ST_HOLD;
      ST_HOLD: if (Out_ready) next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; In_ready is masked while reset is asserted.
  always_comb begin
    In_ready  = (state == ST_IDLE) & ~RST;
    Out_valid = (state == ST_HOLD);
  end

  // Datapath: operand load, serial shift/add, and result capture on the last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c_q  <= 1'b0;
      cnt  <= '0;
      Sum  <= '0;
      Cout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (In_valid) begin
            a_sh <= A;
            b_sh <= B;
            c_q  <= Cin;
            cnt  <= '0;
          end
        end
        ST_ADD: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh <= s_next;
          c_q  <= fa_cout;
          // The counter parks at its last value rather than wrapping.
          if (last_bit) begin
            Sum  <= s_next;
            Cout <= fa_cout;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed scenarios on an 8-bit instance and
// randomized traffic on 8-bit and 2-bit instances against an arithmetic model.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [7:0] a, b, sum;

  logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2;
  logic [1:0] a2, b2, sum2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .In_valid(in_valid), .In_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Out_valid(out_valid), .Out_ready(out_ready),
    .Sum(sum), .Cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .CLK(clk), .RST(rst), .In_valid(in_valid2), .In_ready(in_ready2),
    .A(a2), .B(b2), .Cin(cin2), .Out_valid(out_valid2), .Out_ready(out_ready2),
    .Sum(sum2), .Cout(cout2)
  );

  // Present operands on the 8-bit instance for exactly one rising edge.
  task automatic start_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_c);
    @(negedge clk);
    a = op_a; b = op_b; cin = op_c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
  endtask

  // Wait (bounded) for a result on the 8-bit instance.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!out_valid && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Accept the pending result on the 8-bit instance.
  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b sum=%h cout=%b ready=%b, required 0 00 0 0",
               out_valid, sum, cout, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b/%b, required 1/1", in_ready, in_ready2);
    end
  endtask

  task automatic test_zero_latency();
    int n;
    start_op(8'h00, 8'h00, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== (k == 9)) begin
        fails++;
        $display("FAIL latency_cycle_%0d: ready=%b valid=%b, required ready=0 valid=%b",
                 k, in_ready, out_valid, (k == 9));
      end
    end
    wait_valid(5, n);
    checks++;
    if ({cout, sum} !== 9'h000) begin
      fails++;
      $display("FAIL zero_sum: got %h, required 000", {cout, sum});
    end
    take_result();
  endtask

  task automatic test_carry();
    int n;
    logic [7:0] ta [3] = '{8'hFF, 8'hA5, 8'h12};
    logic [7:0] tb [3] = '{8'h01, 8'h5A, 8'h34};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] te [3] = '{9'h100, 9'h100, 9'h046};
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], tc[i]);
      wait_valid(20, n);
      checks++;
      if (out_valid !== 1'b1 || {cout, sum} !== te[i]) begin
        fails++;
        $display("FAIL carry_%0d: valid=%b result=%h, required 1 %h", i, out_valid, {cout, sum}, te[i]);
      end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    int n;
    start_op(8'h3C, 8'h0F, 1'b0);
    wait_valid(20, n);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k == 1);
      a = 8'h77; b = 8'h11; cin = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h4B || cout !== 1'b0) begin
        fails++;
        $display("FAIL stall_%0d: valid=%b ready=%b sum=%h cout=%b, required 1 0 4b 0",
                 k, out_valid, in_ready, sum, cout);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h4B) begin
        fails++;
        $display("FAIL ignored_ops: valid=%b ready=%b sum=%h, required 0 1 4b", out_valid, in_ready, sum);
      end
    end
  endtask

  task automatic test_reset_mid_add();
    start_op(8'hFF, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_state: valid=%b sum=%h cout=%b ready=%b, required 0 00 0 1",
               out_valid, sum, cout, in_ready);
    end
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL abort_stale: valid=%b ready=%b, required 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random_w8();
    logic [8:0] q[$];
    logic [8:0] exp;
    int got = 0;
    int cyc = 0;
    while (got < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      in_valid  = 1'($urandom);
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) q.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
      if (out_valid && out_ready) begin
        checks++;
        exp = (q.size() != 0) ? q.pop_front() : 9'bx;
        if ({cout, sum} !== exp) begin
          fails++;
          $display("FAIL rand_w8_%0d: got %h, required %h", got, {cout, sum}, exp);
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got < 1000) begin
      fails++;
      $display("FAIL rand_w8_timeout: got %0d results, required 1000", got);
    end
  endtask

  task automatic test_random_w2();
    logic [2:0] q[$];
    logic [2:0] exp;
    int got = 0;
    int cyc = 0;
    while (got < 1000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      in_valid2  = 1'($urandom);
      a2         = 2'($urandom);
      b2         = 2'($urandom);
      cin2       = 1'($urandom);
      out_ready2 = ($urandom_range(0, 3) != 0);
      if (in_valid2 && in_ready2) q.push_back({1'b0, a2} + {1'b0, b2} + 3'(cin2));
      if (out_valid2 && out_ready2) begin
        checks++;
        exp = (q.size() != 0) ? q.pop_front() : 3'bx;
        if ({cout2, sum2} !== exp) begin
          fails++;
          $display("FAIL rand_w2_%0d: got %h, required %h", got, {cout2, sum2}, exp);
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    out_ready2 = 1'b0;
    checks++;
    if (got < 1000) begin
      fails++;
      $display("FAIL rand_w2_timeout: got %0d results, required 1000", got);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0; out_ready2 = 1'b0;
    test_reset();
    test_zero_latency();
    test_carry();
    test_backpressure();
    test_reset_mid_add();
    test_random_w8();
    test_random_w2();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
